cp0_unit: RTL

//  Coprocessor-0 for the static MIPS pipeline; the consumer end of the decoder's mfc0/mtc0/eret/exception/cause/cp0Addr control outputs.

---
 rtl/cp0_pkg.sv | 26 ++
 rtl/cp0_timer.sv | 57 +++++
 rtl/cp0_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, exception codes, Status/Cause field positions.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    localparam int STATUS_IE_BIT    = 0;
    localparam int STATUS_STACK_SH  = 5;
    localparam int CAUSE_IP7_BIT    = 15;

    // Assemble the architecturally visible Cause value from stored fields and the timer flag.
    function automatic logic [31:0] cause_view(input logic [31:0] cause_q, input logic ip7);
        logic [31:0] v;
        v = cause_q & 32'h0000_037C;
        v[CAUSE_IP7_BIT] = ip7;
        return v;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky match flag; built only when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pending
);

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        pending_r;
    logic [31:0] count_inc_s;
    logic [31:0] count_next_s;
    logic        match_s;

    // Next Count value and compare against the post-increment count.
    always_comb begin
        count_inc_s  = count_r + 32'd1;
        count_next_s = count_inc_s;
        match_s      = 1'b0;
        if (count_we) begin
            count_next_s = wdata;
        end else begin
            count_next_s = count_inc_s;
            match_s      = (count_inc_s == compare_r);
        end
    end

    // Timer state; a Compare write acknowledges the pending interrupt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            pending_r <= 1'b0;
        end else if (ena) begin
            count_r <= count_next_s;
            if (compare_we) begin
                compare_r <= wdata;
                pending_r <= 1'b0;
            end else if (match_s) begin
                pending_r <= 1'b1;
            end
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign pending = pending_r;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: Status/Cause/EPC with exception push/pop of the Status mask stack.
// Optional Count/Compare timer is built when the CP0_TIMER_EN macro is defined.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0004,
    parameter logic [31:0] STATUS_INIT = 32'h0000_000F
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic        eret,
    input  logic        exception,
    input  logic [4:0]  cause,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] exc_addr,
    output logic        timer_irq
);

    logic [31:0] status_r;
    logic [31:0] cause_r;
    logic [31:0] epc_r;
    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        pending_s;
    logic        wr_s;
    logic [31:0] rdata_s;
    logic [31:0] exc_addr_s;

    // mtc0 only lands when neither exception nor eret claims the cycle.
    assign wr_s = mtc0 & ~exception & ~eret;

`ifdef CP0_TIMER_EN
    logic count_we_s;
    logic compare_we_s;

    assign count_we_s   = wr_s & (cp0_addr == CP0_COUNT);
    assign compare_we_s = wr_s & (cp0_addr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .count_we   (count_we_s),
        .compare_we (compare_we_s),
        .wdata      (wdata),
        .count      (count_s),
        .compare    (compare_s),
        .pending    (pending_s)
    );

    assign timer_irq = pending_s & status_r[STATUS_IE_BIT];
`else
    assign count_s   = 32'd0;
    assign compare_s = 32'd0;
    assign pending_s = 1'b0;
    assign timer_irq = 1'b0;
`endif

    // Status/Cause/EPC update with exception > eret > mtc0 priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_r <= STATUS_INIT;
            cause_r  <= 32'd0;
            epc_r    <= 32'd0;
        end else if (ena) begin
            if (exception) begin
                status_r     <= status_r << STATUS_STACK_SH;
                cause_r[6:2] <= cause;
                epc_r        <= pc;
            end else if (eret) begin
                status_r <= status_r >> STATUS_STACK_SH;
            end else if (wr_s) begin
                case (cp0_addr)
                    CP0_STATUS: status_r     <= wdata;
                    CP0_CAUSE:  cause_r[9:8] <= wdata[9:8];
                    CP0_EPC:    epc_r        <= wdata;
                    default:    ;
                endcase
            end
        end
    end

    // mfc0 read mux; reflects pre-edge contents so a same-cycle mtc0 is not seen.
    always_comb begin
        rdata_s = 32'd0;
        if (mfc0) begin
            case (cp0_addr)
                CP0_STATUS:  rdata_s = status_r;
                CP0_CAUSE:   rdata_s = cause_view(cause_r, pending_s);
                CP0_EPC:     rdata_s = epc_r;
                CP0_COUNT:   rdata_s = count_s;
                CP0_COMPARE: rdata_s = compare_s;
                default:     rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // PC-mux target: EPC for eret, otherwise the fixed exception vector.
    always_comb begin
        exc_addr_s = EXC_VECTOR;
        if (eret) begin
            exc_addr_s = epc_r;
        end else begin
            exc_addr_s = EXC_VECTOR;
        end
    end

    assign rdata    = rdata_s;
    assign exc_addr = exc_addr_s;
    assign status   = status_r;

endmodule
